control_unit: RTL and testbench
===============================

# control_unit

Hardwired sequencer for the single-bus CPU datapath. It steps every instruction through fetch and a per-class execute sequence, and drives the datapath's one-hot control strobes cycle by cycle. It reads only `opcode` (from the IR select/encode logic) and the branch flag `con_out`. It owns run/halt state and the external stop request.

## Interface
Parameters:
- `STEP_W`, 4: width of the debug step output.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `opcode` in 5: current IR opcode; stable from step T3 onward.
- `con_out` in 1: branch condition flag from the CON FF.
- `stop` in 1: level request to halt after the current instruction.
- `step_in` in 1: single-step pulse; present only with `CTRL_SINGLE_STEP_EN`.
- Bus-source strobes, out 1 each: `pc_out`, `zlo_out`, `zhi_out`, `mdr_out`, `hi_out`, `lo_out`, `c_out`, `inport_out`, `ba_out`, `r_out`.
- Register-load strobes, out 1 each: `pc_enable`, `pc_increment`, `ir_enable`, `mar_enable`, `mdr_enable`, `mdr_read`, `y_enable`, `zlo_enable`, `zhi_enable`, `hi_enable`, `lo_enable`, `r_in`, `con_enable`, `outport_enable`, `ram_enable`.
- Register-field selects, out 1 each: `gra`, `grb`, `grc`.
- `link_in` out 1: load enable for R15, used only by JAL.
- `run` out 1: 1 while executing, 0 when halted.
- `step` out `STEP_W`: current T-step, for debug.

## Operation
State register: `T0`..`T7`, plus `HALTED`. All strobes are decoded combinationally from the state and `opcode`. Any strobe not listed for a step is 0.

Fetch, identical for every instruction:
- T0: `pc_out`, `mar_enable`, `pc_increment`.
- T1: `mdr_read`, `mdr_enable`.
- T2: `mdr_out`, `ir_enable`.

Execute, per opcode class. The last listed step returns to T0.
- ALU register ops (ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010):
  - T3: `grb`,`r_out`,`y_enable`
  - T4: `grc`,`r_out`,`zlo_enable`
  - T5: `zlo_out`,`gra`,`r_in`
- Immediate ops (ADDI 01011, ANDI 01100, ORI 01101): same as ALU register ops, except T4 drives `c_out` in place of `grc`,`r_out`.
- LDI (00001):
  - T3: `grb`,`r_out`,`ba_out`,`y_enable`
  - T4: `c_out`,`zlo_enable`
  - T5: `zlo_out`,`gra`,`r_in`
- LD (00000):
  - T3–T4: as LDI.
  - T5: `zlo_out`,`mar_enable`
  - T6: `mdr_read`,`mdr_enable`
  - T7: `mdr_out`,`gra`,`r_in`
- ST (00010):
  - T3–T5: as LD.
  - T6: `gra`,`r_out`,`mdr_enable` (`mdr_read`=0)
  - T7: `ram_enable`
- NEG (10000), NOT (10001):
  - T3: `grb`,`r_out`,`zlo_enable`
  - T4: `zlo_out`,`gra`,`r_in`
- MUL (01110), DIV (01111):
  - T3: `gra`,`r_out`,`y_enable`
  - T4: `grb`,`r_out`,`zlo_enable`,`zhi_enable`
  - T5: `zlo_out`,`lo_enable`
  - T6: `zhi_out`,`hi_enable`
- BR (10010):
  - T3: `gra`,`r_out`,`con_enable`
  - T4: `pc_out`,`y_enable`
  - T5: `c_out`,`zlo_enable`
  - T6: `zlo_out`; `pc_enable` = `con_out`
- JR (10011): T3: `gra`,`r_out`,`pc_enable`.
- JAL (10100):
  - T3: `pc_out`,`link_in`
  - T4: `gra`,`r_out`,`pc_enable`
- IN (10101): T3: `inport_out`,`gra`,`r_in`.
- OUT (10110): T3: `gra`,`r_out`,`outport_enable`.
- MFHI (10111): T3: `hi_out`,`gra`,`r_in`. MFLO (11000): same with `lo_out` in place of `hi_out`.
- NOP (11001) and all undefined opcodes: T3 with no strobes, then T0.
- HALT (11010): T3 transitions to `HALTED`.

Run/halt:
- Halt is entered by HALT, or by `stop`=1 sampled in an instruction's final step; in the `stop` case the next state is `HALTED`, not T0.
- In `HALTED`: `run`=0, all strobes 0. Only `clr` exits `HALTED`.

## Timing
- Reset: `clr`=1 at an edge forces state T0 and `run`=1.
  - While `clr` is high, all strobes are forced to 0 and `step`=0.
  - `clr` overrides `stop`, HALT and `step_in`.
  - `clr` in mid-instruction abandons it; no partial write is completed.
- The memory read is assumed valid one cycle after the MAR load, so T1 and T6 capture RAM data.
- Cycle counts, including fetch:
  - 4: JR, IN, OUT, MFHI, MFLO, NOP.
  - 5: NEG, NOT, JAL.
  - 6: ALU register ops, immediate ops, LDI.
  - 7: MUL, DIV, BR.
  - 8: LD, ST.
- `con_out` is sampled combinationally in BR T6 only; the CON FF was loaded at the end of T3.
- `step` equals the T index; it reads 0xF in `HALTED`.

## Configuration
`CTRL_SINGLE_STEP_EN`
- Defined:
  - After each instruction's final step, the FSM waits in T0 with all strobes masked until a `step_in` rising edge is seen. `run`=0 while waiting.
  - A `step_in` pulse held high across multiple cycles counts once.
  - `stop` still takes precedence and enters `HALTED`.
- Undefined: the `step_in` port is absent and the FSM free-runs.

## Structure
- Package `cpu_ctrl_pkg`:
  - opcode localparams (5-bit, values above);
  - the state enum (T0–T7, `HALTED`);
  - a packed control-word struct holding all strobes.
- Sub-module `ctrl_decode`: purely combinational (state, opcode, `con_out`) → control word.
- `control_unit` holds the state register, run/halt logic, the single-step edge detector and clr masking.

## Test plan
- Reset, then ADD (opcode 00011):
  - T0: `pc_out`=`mar_enable`=`pc_increment`=1.
  - T5: `zlo_out`=`gra`=`r_in`=1.
  - Back at T0 on cycle 6.
- LD then ST back-to-back: LD asserts `mdr_read`=1 in T6; ST asserts `mdr_read`=0 with `mdr_enable`=1 in T6 and `ram_enable`=1 in T7. Total 16 cycles.
- BR with `con_out`=0, then `con_out`=1: `pc_enable` is 0, then 1, in T6. No other strobes differ between the two runs.
- HALT (11010): state `HALTED` after T3, `run`=0, strobes 0 for 20 cycles. A `clr` pulse returns to T0 with `run`=1.
- `stop` raised during MUL T4: MUL completes with `hi_enable` in T6, then enters `HALTED`. `clr`=1 during LD T5 gives T0 next cycle with `mar_enable` never asserted.
- With `CTRL_SINGLE_STEP_EN`: after a NOP the FSM stays idle, with no strobes, until `step_in` goes 0→1. A 3-cycle-wide `step_in` pulse advances exactly one instruction.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired CPU sequencer: opcodes, T-step state and the control word.
// Instruction length lookup lives here so the top and any checker agree on it.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // HALTED encodes as 0xF so the debug step output can show the state directly.
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALTED = 4'hF
  } state_t;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, inport_out, ba_out, r_out;
    logic pc_enable, pc_increment, ir_enable, mar_enable, mdr_enable, mdr_read, y_enable;
    logic zlo_enable, zhi_enable, hi_enable, lo_enable, r_in, con_enable, outport_enable, ram_enable;
    logic gra, grb, grc, link_in;
  } ctrl_word_t;

  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                                 return T7;
      OP_MUL, OP_DIV, OP_BR:                        return T6;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI,
      OP_LDI:                                       return T5;
      OP_NEG, OP_NOT, OP_JAL:                       return T4;
      default:                                      return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Sequencer <-> datapath bundle: opcode/flags in, one-hot strobes and run/step out.
// step_in exists only when CTRL_SINGLE_STEP_EN is defined.
interface control_unit_if #(parameter int STEP_W = 4);
  logic [4:0] opcode;
  logic con_out, stop;
`ifdef CTRL_SINGLE_STEP_EN
  logic step_in;
`endif
  logic pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, inport_out, ba_out, r_out;
  logic pc_enable, pc_increment, ir_enable, mar_enable, mdr_enable, mdr_read, y_enable;
  logic zlo_enable, zhi_enable, hi_enable, lo_enable, r_in, con_enable, outport_enable, ram_enable;
  logic gra, grb, grc, link_in, run;
  logic [STEP_W-1:0] step;

  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input step_in,
`endif
    input opcode, con_out, stop,
    output pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, inport_out, ba_out, r_out,
    output pc_enable, pc_increment, ir_enable, mar_enable, mdr_enable, mdr_read, y_enable,
    output zlo_enable, zhi_enable, hi_enable, lo_enable, r_in, con_enable, outport_enable, ram_enable,
    output gra, grb, grc, link_in, run, step
  );

  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step_in,
`endif
    output opcode, con_out, stop,
    input pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, inport_out, ba_out, r_out,
    input pc_enable, pc_increment, ir_enable, mar_enable, mdr_enable, mdr_read, y_enable,
    input zlo_enable, zhi_enable, hi_enable, lo_enable, r_in, con_enable, outport_enable, ram_enable,
    input gra, grb, grc, link_in, run, step
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (T-step, opcode, con_out); HALTED yields an all-zero word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [4:0] opcode_i,
  input  logic       con_out_i,
  output ctrl_word_t cw_o
);
  logic is_alu, is_imm, is_ldi, is_mem, is_st, is_neg, is_md;

  assign is_alu = opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  assign is_imm = opcode_i inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_ldi = (opcode_i == OP_LDI);
  assign is_mem = opcode_i inside {OP_LD, OP_ST};
  assign is_st  = (opcode_i == OP_ST);
  assign is_neg = opcode_i inside {OP_NEG, OP_NOT};
  assign is_md  = opcode_i inside {OP_MUL, OP_DIV};

  always_comb begin
    cw_o = '0;
    case (state_i)
      T0: begin cw_o.pc_out = 1'b1; cw_o.mar_enable = 1'b1; cw_o.pc_increment = 1'b1; end
      T1: begin cw_o.mdr_read = 1'b1; cw_o.mdr_enable = 1'b1; end
      T2: begin cw_o.mdr_out = 1'b1; cw_o.ir_enable = 1'b1; end
      T3: begin
        if (is_alu || is_imm) begin
          cw_o.grb = 1'b1; cw_o.r_out = 1'b1; cw_o.y_enable = 1'b1;
        end else if (is_ldi || is_mem) begin
          cw_o.grb = 1'b1; cw_o.r_out = 1'b1; cw_o.ba_out = 1'b1; cw_o.y_enable = 1'b1;
        end else if (is_neg) begin
          cw_o.grb = 1'b1; cw_o.r_out = 1'b1; cw_o.zlo_enable = 1'b1;
        end else if (is_md) begin
          cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.y_enable = 1'b1;
        end else begin
          case (opcode_i)
            OP_BR:   begin cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.con_enable = 1'b1; end
            OP_JR:   begin cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.pc_enable = 1'b1; end
            OP_JAL:  begin cw_o.pc_out = 1'b1; cw_o.link_in = 1'b1; end
            OP_IN:   begin cw_o.inport_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1; end
            OP_OUT:  begin cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.outport_enable = 1'b1; end
            OP_MFHI: begin cw_o.hi_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1; end
            OP_MFLO: begin cw_o.lo_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1; end
            default: ;
          endcase
        end
      end
      T4: begin
        if (is_alu) begin
          cw_o.grc = 1'b1; cw_o.r_out = 1'b1; cw_o.zlo_enable = 1'b1;
        end else if (is_imm || is_ldi || is_mem) begin
          cw_o.c_out = 1'b1; cw_o.zlo_enable = 1'b1;
        end else if (is_neg) begin
          cw_o.zlo_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
        end else if (is_md) begin
          cw_o.grb = 1'b1; cw_o.r_out = 1'b1; cw_o.zlo_enable = 1'b1; cw_o.zhi_enable = 1'b1;
        end else if (opcode_i == OP_BR) begin
          cw_o.pc_out = 1'b1; cw_o.y_enable = 1'b1;
        end else if (opcode_i == OP_JAL) begin
          cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.pc_enable = 1'b1;
        end
      end
      T5: begin
        if (is_alu || is_imm || is_ldi) begin
          cw_o.zlo_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
        end else if (is_mem) begin
          cw_o.zlo_out = 1'b1; cw_o.mar_enable = 1'b1;
        end else if (is_md) begin
          cw_o.zlo_out = 1'b1; cw_o.lo_enable = 1'b1;
        end else if (opcode_i == OP_BR) begin
          cw_o.c_out = 1'b1; cw_o.zlo_enable = 1'b1;
        end
      end
      T6: begin
        if (is_st) begin
          cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.mdr_enable = 1'b1;
        end else if (is_mem) begin
          cw_o.mdr_read = 1'b1; cw_o.mdr_enable = 1'b1;
        end else if (is_md) begin
          cw_o.zhi_out = 1'b1; cw_o.hi_enable = 1'b1;
        end else if (opcode_i == OP_BR) begin
          // The CON FF was loaded in T3, so the branch decision is taken live here.
          cw_o.zlo_out = 1'b1; cw_o.pc_enable = con_out_i;
        end
      end
      T7: begin
        if (is_st) begin
          cw_o.ram_enable = 1'b1;
        end else if (is_mem) begin
          cw_o.mdr_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Hardwired CPU sequencer: T-step state register, run/halt, clr masking and strobe fan-out.
// Optional CTRL_SINGLE_STEP_EN: park in T0 after each instruction until a step_in rising edge.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input logic            clk,
  input logic            clr,
  control_unit_if.master bus
);
  state_t     state_q;
  ctrl_word_t cw, cw_m;
  logic       at_last, idle;

  assign at_last = (state_q == last_step(bus.opcode));

`ifdef CTRL_SINGLE_STEP_EN
  logic wait_q, step_in_q, step_rise;
  assign step_rise = bus.step_in & ~step_in_q;
  assign idle      = wait_q;
`else
  assign idle      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= T0;
`ifdef CTRL_SINGLE_STEP_EN
      wait_q    <= 1'b0;
      step_in_q <= bus.step_in;
`endif
    end else begin
`ifdef CTRL_SINGLE_STEP_EN
      step_in_q <= bus.step_in;
`endif
      if (state_q == HALTED) begin
        state_q <= HALTED;
`ifdef CTRL_SINGLE_STEP_EN
      end else if (wait_q) begin
        if (bus.stop) state_q <= HALTED;
        else if (step_rise) wait_q <= 1'b0;
`endif
      end else if (state_q == T3 && bus.opcode == OP_HALT) begin
        state_q <= HALTED;
      end else if (at_last) begin
        if (bus.stop) begin
          state_q <= HALTED;
        end else begin
          state_q <= T0;
`ifdef CTRL_SINGLE_STEP_EN
          wait_q  <= 1'b1;
`endif
        end
      end else begin
        state_q <= state_t'(state_q + 4'd1);
      end
    end
  end

  ctrl_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (bus.opcode),
    .con_out_i (bus.con_out),
    .cw_o      (cw)
  );

  // clr and the single-step wait both silence the datapath without touching the decode.
  assign cw_m     = (clr || idle) ? '0 : cw;
  assign bus.run  = (state_q != HALTED) && !idle;
  assign bus.step = clr ? '0 : STEP_W'(state_q);

  assign bus.pc_out         = cw_m.pc_out;
  assign bus.zlo_out        = cw_m.zlo_out;
  assign bus.zhi_out        = cw_m.zhi_out;
  assign bus.mdr_out        = cw_m.mdr_out;
  assign bus.hi_out         = cw_m.hi_out;
  assign bus.lo_out         = cw_m.lo_out;
  assign bus.c_out          = cw_m.c_out;
  assign bus.inport_out     = cw_m.inport_out;
  assign bus.ba_out         = cw_m.ba_out;
  assign bus.r_out          = cw_m.r_out;
  assign bus.pc_enable      = cw_m.pc_enable;
  assign bus.pc_increment   = cw_m.pc_increment;
  assign bus.ir_enable      = cw_m.ir_enable;
  assign bus.mar_enable     = cw_m.mar_enable;
  assign bus.mdr_enable     = cw_m.mdr_enable;
  assign bus.mdr_read       = cw_m.mdr_read;
  assign bus.y_enable       = cw_m.y_enable;
  assign bus.zlo_enable     = cw_m.zlo_enable;
  assign bus.zhi_enable     = cw_m.zhi_enable;
  assign bus.hi_enable      = cw_m.hi_enable;
  assign bus.lo_enable      = cw_m.lo_enable;
  assign bus.r_in           = cw_m.r_in;
  assign bus.con_enable     = cw_m.con_enable;
  assign bus.outport_enable = cw_m.outport_enable;
  assign bus.ram_enable     = cw_m.ram_enable;
  assign bus.gra            = cw_m.gra;
  assign bus.grb            = cw_m.grb;
  assign bus.grc            = cw_m.grc;
  assign bus.link_in        = cw_m.link_in;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step strobe words written by hand, run/halt and clr cases.
module tb_control_unit;
  localparam logic [28:0] PC_OUT = 29'd1 << 0,  ZLO_OUT = 29'd1 << 1,  ZHI_OUT = 29'd1 << 2;
  localparam logic [28:0] MDR_OUT = 29'd1 << 3, HI_OUT = 29'd1 << 4,   LO_OUT = 29'd1 << 5;
  localparam logic [28:0] C_OUT = 29'd1 << 6,   INP_OUT = 29'd1 << 7,  BA_OUT = 29'd1 << 8;
  localparam logic [28:0] R_OUT = 29'd1 << 9,   PC_EN = 29'd1 << 10,   PC_INC = 29'd1 << 11;
  localparam logic [28:0] IR_EN = 29'd1 << 12,  MAR_EN = 29'd1 << 13,  MDR_EN = 29'd1 << 14;
  localparam logic [28:0] MDR_RD = 29'd1 << 15, Y_EN = 29'd1 << 16,    ZLO_EN = 29'd1 << 17;
  localparam logic [28:0] ZHI_EN = 29'd1 << 18, HI_EN = 29'd1 << 19,   LO_EN = 29'd1 << 20;
  localparam logic [28:0] R_IN = 29'd1 << 21,   CON_EN = 29'd1 << 22,  OUTP_EN = 29'd1 << 23;
  localparam logic [28:0] RAM_EN = 29'd1 << 24, GRA = 29'd1 << 25,     GRB = 29'd1 << 26;
  localparam logic [28:0] GRC = 29'd1 << 27,    LINK = 29'd1 << 28;
  localparam logic [28:0] F0 = PC_OUT | MAR_EN | PC_INC;
  localparam logic [28:0] F1 = MDR_RD | MDR_EN;
  localparam logic [28:0] F2 = MDR_OUT | IR_EN;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [28:0] exp_q[$];

  control_unit_if #(.STEP_W(4)) bus ();
  control_unit #(.STEP_W(4)) dut (.clk(clk), .clr(clr), .bus(bus));

  // clock / reset-time infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] obs_word();
    logic [28:0] w;
    w = '0;
    w[0] = bus.pc_out;      w[1] = bus.zlo_out;       w[2] = bus.zhi_out;     w[3] = bus.mdr_out;
    w[4] = bus.hi_out;      w[5] = bus.lo_out;        w[6] = bus.c_out;       w[7] = bus.inport_out;
    w[8] = bus.ba_out;      w[9] = bus.r_out;         w[10] = bus.pc_enable;  w[11] = bus.pc_increment;
    w[12] = bus.ir_enable;  w[13] = bus.mar_enable;   w[14] = bus.mdr_enable; w[15] = bus.mdr_read;
    w[16] = bus.y_enable;   w[17] = bus.zlo_enable;   w[18] = bus.zhi_enable; w[19] = bus.hi_enable;
    w[20] = bus.lo_enable;  w[21] = bus.r_in;         w[22] = bus.con_enable; w[23] = bus.outport_enable;
    w[24] = bus.ram_enable; w[25] = bus.gra;          w[26] = bus.grb;        w[27] = bus.grc;
    w[28] = bus.link_in;
    return w;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch();
    exp_q.push_back(F0);
    exp_q.push_back(F1);
    exp_q.push_back(F2);
  endtask

  // driver: present op and walk steps first..last, comparing each against the expected queue
  task automatic run_instr(input string name, input logic [4:0] op, input int first,
                           input int last, input int stop_at);
    logic [28:0] e;
    bus.opcode = op;
    for (int i = first; i <= last; i++) begin
      if (i == stop_at) bus.stop = 1'b1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 29'h1fff_ffff;
      chk($sformatf("%s_T%0d_step", name, i), 32'(bus.step), 32'(i));
      chk($sformatf("%s_T%0d_run", name, i), 32'(bus.run), 32'd1);
      chk($sformatf("%s_T%0d_word", name, i), 32'(obs_word()), 32'(e));
      tick();
    end
  endtask

  task automatic chk_halted(input string name);
    chk({name, "_step"}, 32'(bus.step), 32'hF);
    chk({name, "_run"}, 32'(bus.run), 32'd0);
    chk({name, "_word"}, 32'(obs_word()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int c0;
    clr = 1'b1;
    bus.opcode = 5'b11001;
    bus.con_out = 1'b0;
    bus.stop = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    bus.step_in = 1'b0;
`endif
    tick();
    tick();
    chk("rst_clr_step", 32'(bus.step), 32'd0);
    chk("rst_clr_word", 32'(obs_word()), 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_run", 32'(bus.run), 32'd1);

`ifdef CTRL_SINGLE_STEP_EN
    push_fetch(); exp_q.push_back('0);
    run_instr("ss_nop", 5'b11001, 0, 3, -1);
    for (int k = 0; k < 5; k++) begin
      chk("ss_wait_step", 32'(bus.step), 32'd0);
      chk("ss_wait_run", 32'(bus.run), 32'd0);
      chk("ss_wait_word", 32'(obs_word()), 32'd0);
      tick();
    end
    bus.step_in = 1'b1;
    tick();
    push_fetch(); exp_q.push_back('0);
    run_instr("ss_nop2a", 5'b11001, 0, 1, -1);
    bus.step_in = 1'b0;
    run_instr("ss_nop2b", 5'b11001, 2, 3, -1);
    for (int k = 0; k < 4; k++) begin
      chk("ss_once_run", 32'(bus.run), 32'd0);
      chk("ss_once_word", 32'(obs_word()), 32'd0);
      tick();
    end
    bus.stop = 1'b1;
    tick();
    chk_halted("ss_stop");
`else
    // ADD
    push_fetch();
    exp_q.push_back(GRB | R_OUT | Y_EN);
    exp_q.push_back(GRC | R_OUT | ZLO_EN);
    exp_q.push_back(ZLO_OUT | GRA | R_IN);
    c0 = cyc;
    run_instr("add", 5'b00011, 0, 5, -1);
    chk("add_cycles", 32'(cyc - c0), 32'd6);
    chk("add_back_t0", 32'(bus.step), 32'd0);

    // LD then ST back to back
    push_fetch();
    exp_q.push_back(GRB | R_OUT | BA_OUT | Y_EN);
    exp_q.push_back(C_OUT | ZLO_EN);
    exp_q.push_back(ZLO_OUT | MAR_EN);
    exp_q.push_back(MDR_RD | MDR_EN);
    exp_q.push_back(MDR_OUT | GRA | R_IN);
    push_fetch();
    exp_q.push_back(GRB | R_OUT | BA_OUT | Y_EN);
    exp_q.push_back(C_OUT | ZLO_EN);
    exp_q.push_back(ZLO_OUT | MAR_EN);
    exp_q.push_back(GRA | R_OUT | MDR_EN);
    exp_q.push_back(RAM_EN);
    c0 = cyc;
    run_instr("ld", 5'b00000, 0, 7, -1);
    run_instr("st", 5'b00010, 0, 7, -1);
    chk("ldst_cycles", 32'(cyc - c0), 32'd16);

    // BR not taken, then taken: only pc_enable in T6 differs
    for (int t = 0; t < 2; t++) begin
      bus.con_out = (t == 1);
      push_fetch();
      exp_q.push_back(GRA | R_OUT | CON_EN);
      exp_q.push_back(PC_OUT | Y_EN);
      exp_q.push_back(C_OUT | ZLO_EN);
      exp_q.push_back(ZLO_OUT | ((t == 1) ? PC_EN : 29'd0));
      run_instr((t == 1) ? "br_taken" : "br_not", 5'b10010, 0, 6, -1);
    end
    bus.con_out = 1'b0;

    // short and medium classes
    push_fetch(); exp_q.push_back(GRB | R_OUT | ZLO_EN); exp_q.push_back(ZLO_OUT | GRA | R_IN);
    run_instr("neg", 5'b10000, 0, 4, -1);
    push_fetch(); exp_q.push_back(PC_OUT | LINK); exp_q.push_back(GRA | R_OUT | PC_EN);
    run_instr("jal", 5'b10100, 0, 4, -1);
    push_fetch(); exp_q.push_back(GRA | R_OUT | PC_EN);
    run_instr("jr", 5'b10011, 0, 3, -1);
    push_fetch(); exp_q.push_back(INP_OUT | GRA | R_IN);
    run_instr("in", 5'b10101, 0, 3, -1);
    push_fetch(); exp_q.push_back(GRA | R_OUT | OUTP_EN);
    run_instr("out", 5'b10110, 0, 3, -1);
    push_fetch(); exp_q.push_back(HI_OUT | GRA | R_IN);
    run_instr("mfhi", 5'b10111, 0, 3, -1);
    push_fetch(); exp_q.push_back(LO_OUT | GRA | R_IN);
    run_instr("mflo", 5'b11000, 0, 3, -1);
    push_fetch(); exp_q.push_back('0);
    run_instr("undef", 5'b11111, 0, 3, -1);
    push_fetch();
    exp_q.push_back(GRB | R_OUT | Y_EN); exp_q.push_back(C_OUT | ZLO_EN);
    exp_q.push_back(ZLO_OUT | GRA | R_IN);
    run_instr("addi", 5'b01011, 0, 5, -1);
    push_fetch();
    exp_q.push_back(GRB | R_OUT | BA_OUT | Y_EN); exp_q.push_back(C_OUT | ZLO_EN);
    exp_q.push_back(ZLO_OUT | GRA | R_IN);
    run_instr("ldi", 5'b00001, 0, 5, -1);

    // clr in LD T5 abandons the instruction before the MAR load
    push_fetch();
    exp_q.push_back(GRB | R_OUT | BA_OUT | Y_EN); exp_q.push_back(C_OUT | ZLO_EN);
    run_instr("ld_abort", 5'b00000, 0, 4, -1);
    clr = 1'b1;
    #1;
    chk("clr_t5_word", 32'(obs_word()), 32'd0);
    chk("clr_t5_step", 32'(bus.step), 32'd0);
    tick();
    clr = 1'b0;
    #1;
    chk("clr_next_step", 32'(bus.step), 32'd0);
    chk("clr_next_word", 32'(obs_word()), 32'(F0));

    // stop raised in MUL T4: MUL finishes, then halts
    push_fetch();
    exp_q.push_back(GRA | R_OUT | Y_EN); exp_q.push_back(GRB | R_OUT | ZLO_EN | ZHI_EN);
    exp_q.push_back(ZLO_OUT | LO_EN); exp_q.push_back(ZHI_OUT | HI_EN);
    run_instr("mul_stop", 5'b01110, 0, 6, 4);
    chk_halted("mul_halted");
    bus.stop = 1'b0;
    tick();
    chk_halted("mul_halted_hold");
    pulse_clr();
    #1;
    chk("mul_clr_step", 32'(bus.step), 32'd0);
    chk("mul_clr_run", 32'(bus.run), 32'd1);

    // DIV runs the full 7 cycles
    push_fetch();
    exp_q.push_back(GRA | R_OUT | Y_EN); exp_q.push_back(GRB | R_OUT | ZLO_EN | ZHI_EN);
    exp_q.push_back(ZLO_OUT | LO_EN); exp_q.push_back(ZHI_OUT | HI_EN);
    run_instr("div", 5'b01111, 0, 6, -1);
    chk("div_back_t0", 32'(bus.step), 32'd0);

    // HALT, stay halted for 20 cycles, clr restarts
    push_fetch(); exp_q.push_back('0);
    run_instr("halt", 5'b11010, 0, 3, -1);
    for (int k = 0; k < 20; k++) begin
      chk_halted($sformatf("halt_c%0d", k));
      tick();
    end
    pulse_clr();
    #1;
    chk("halt_clr_step", 32'(bus.step), 32'd0);
    chk("halt_clr_run", 32'(bus.run), 32'd1);
    chk("halt_clr_word", 32'(obs_word()), 32'(F0));
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
